// File: rtl/mat_res_serializer_if.sv
// Handshake bundle between the matrix multiplier result port, the serializer
// and the downstream element stream.
interface mat_res_serializer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                                          c_valid;
  logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0]     c;
  logic                                          c_ready;
  logic [DATA_WIDTH-1:0]                         m_data;
  logic [RW-1:0]                                 m_row;
  logic [CW-1:0]                                 m_col;
  logic                                          m_valid;
  logic                                          m_last;
  logic                                          m_ready;

  // master: the serializer (drives the stream, acknowledges the capture)
  modport master (
    input  c_valid, c, m_ready,
    output c_ready, m_data, m_row, m_col, m_valid, m_last
  );

  modport slave (
    output c_valid, c, m_ready,
    input  c_ready, m_data, m_row, m_col, m_valid, m_last
  );
endinterface

// File: rtl/mat_res_serializer.sv
// Captures a ROWS x COLS result matrix and replays it one element per beat.
// Define MAT_SER_COLMAJOR_EN for column-major replay order (row-major otherwise).
module mat_res_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  mat_res_serializer_if.master bus,
  output logic [15:0]          frame_cnt
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                                    state, state_nxt;
  logic [0:ROWS-1][0:COLS-1][DATA_WIDTH-1:0] mat_buf;
  logic [RW-1:0]                             row;
  logic [CW-1:0]                             col;
  logic                                      row_end, col_end, at_last;
  logic                                      capture, beat;

  assign row_end = (row == RW'(ROWS - 1));
  assign col_end = (col == CW'(COLS - 1));
  assign at_last = row_end && col_end;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.c_ready = 1'b0;
    bus.m_valid = 1'b0;
    capture     = 1'b0;
    beat        = 1'b0;
    case (state)
      IDLE: begin
        bus.c_ready = 1'b1;
        if (bus.c_valid) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        bus.m_valid = 1'b1;
        beat        = bus.m_ready;
        if (bus.m_ready && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer has no reset: its contents are only observable after a capture.
  always_ff @(posedge clk) begin
    if (capture) mat_buf <= bus.c;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      row       <= '0;
      col       <= '0;
      frame_cnt <= '0;
    end else if (capture) begin
      row <= '0;
      col <= '0;
    end else if (beat) begin
      if (at_last) begin
        row       <= '0;
        col       <= '0;
        frame_cnt <= frame_cnt + 16'd1;
      end else begin
`ifdef MAT_SER_COLMAJOR_EN
        if (row_end) begin
          row <= '0;
          col <= col + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
`else
        if (col_end) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
`endif
      end
    end
  end

  assign bus.m_data = (state == STREAM) ? mat_buf[row][col] : '0;
  assign bus.m_row  = row;
  assign bus.m_col  = col;
  assign bus.m_last = (state == STREAM) && at_last;

endmodule

// File: tb/tb_mat_res_serializer.sv
// Scoreboard bench for mat_res_serializer: stimulus pushes expected beats,
// a negedge monitor pops and compares each accepted beat.
module tb_mat_res_serializer;
  localparam int DW = 32;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int RW = 2;
  localparam int CW = 2;

  typedef logic [0:R-1][0:C-1][DW-1:0] mat_t;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  mat_res_serializer_if #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) bus ();

  mat_res_serializer #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  beat_t exp_q[$];
  int    checks     = 0;
  int    errors     = 0;
  int    ready_mode = 0;  // 0: always 1, 1: pattern 1,0,0, 2: always 0

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic mat_t pat_a();
    mat_t m;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        m[i][j] = 32'(16 * i + j);
    return m;
  endfunction

  function automatic mat_t pat_b();
    mat_t m;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        m[i][j] = 32'hA5A5_0000 + 32'(i * C + j);
    return m;
  endfunction

  task automatic push_one(input mat_t m, input int i, input int j);
    beat_t b;
    b.data = m[i][j];
    b.row  = RW'(i);
    b.col  = CW'(j);
    b.last = (i == R - 1) && (j == C - 1);
    exp_q.push_back(b);
  endtask

  task automatic push_frame(input mat_t m);
`ifdef MAT_SER_COLMAJOR_EN
    for (int j = 0; j < C; j++)
      for (int i = 0; i < R; i++)
        push_one(m, i, j);
`else
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        push_one(m, i, j);
`endif
  endtask

  // m_ready driver, applied 2 time units after each rising edge
  initial begin
    int k = 0;
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       begin bus.m_ready = (k % 3 == 0); k++; end
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on every beat that will be accepted at the next edge,
  // and checks that stalled outputs hold.
  initial begin
    beat_t cur, prev, e;
    bit    have_prev = 1'b0;
    forever begin
      @(negedge clk);
      cur = {bus.m_data, bus.m_row, bus.m_col, bus.m_last};
      if (have_prev && rstn) check("stall_hold", 64'(cur), 64'(prev));
      have_prev = bus.m_valid && !bus.m_ready && rstn;
      prev      = cur;
      if (rstn && bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat actual data=%0h row=%0d col=%0d required=none",
                   cur.data, cur.row, cur.col);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat actual data=%0h row=%0d col=%0d last=%0b required data=%0h row=%0d col=%0d last=%0b",
                     cur.data, cur.row, cur.col, cur.last, e.data, e.row, e.col, e.last);
          end
        end
      end
    end
  end

  task automatic capture(input mat_t m, input bit hold);
    int n = 0;
    bus.c       = m;
    bus.c_valid = 1'b1;
    push_frame(m);
    @(negedge clk);
    while (!bus.c_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.c_ready) begin
      checks++;
      errors++;
      $display("FAIL capture_timeout actual c_ready=0 required c_ready=1");
    end
    @(posedge clk);
    #1;
    if (!hold) bus.c_valid = 1'b0;
    @(negedge clk);
    check("c_ready_after_capture", 64'(bus.c_ready), 64'd0);
    check("m_valid_latency", 64'(bus.m_valid), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual pending=%0d required pending=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    int n;
    bus.c_valid = 1'b0;
    bus.c       = '0;
    rstn        = 1'b0;
    ready_mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_c_ready",   64'(bus.c_ready), 64'd1);
    check("rst_m_valid",   64'(bus.m_valid), 64'd0);
    check("rst_m_last",    64'(bus.m_last),  64'd0);
    check("rst_m_data",    64'(bus.m_data),  64'd0);
    check("rst_m_row",     64'(bus.m_row),   64'd0);
    check("rst_m_col",     64'(bus.m_col),   64'd0);
    check("rst_frame_cnt", 64'(frame_cnt),   64'd0);
    rstn = 1'b1;

    // Frame at full rate
    capture(pat_a(), 1'b0);
    wait_drain();
    check("frame_cnt_1", 64'(frame_cnt), 64'd1);
    check("idle_c_ready", 64'(bus.c_ready), 64'd1);
    check("idle_m_valid", 64'(bus.m_valid), 64'd0);

    // Frame with downstream backpressure
    ready_mode = 1;
    capture(pat_a(), 1'b0);
    wait_drain();
    check("frame_cnt_2", 64'(frame_cnt), 64'd2);
    ready_mode = 0;

    // Back-to-back frames with c_valid held high
    capture(pat_a(), 1'b1);
    bus.c = pat_b();
    push_frame(pat_b());
    gap = 0;
    n   = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!bus.m_valid) gap++;
      else if (gap > 0) break;
    end
    check("b2b_gap", 64'(gap), 64'd1);
    bus.c_valid = 1'b0;
    bus.c       = '1;
    wait_drain();
    check("frame_cnt_4", 64'(frame_cnt), 64'd4);

    // Reset after five beats
    capture(pat_a(), 1'b0);
    repeat (5) @(posedge clk);
    #1;
    ready_mode = 2;
    rstn       = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_m_valid",   64'(bus.m_valid), 64'd0);
    check("midrst_c_ready",   64'(bus.c_ready), 64'd1);
    check("midrst_frame_cnt", 64'(frame_cnt),   64'd0);
    check("midrst_m_row",     64'(bus.m_row),   64'd0);
    check("midrst_m_col",     64'(bus.m_col),   64'd0);
    rstn       = 1'b1;
    ready_mode = 0;
    capture(pat_b(), 1'b0);
    wait_drain();
    check("frame_cnt_after_rst", 64'(frame_cnt), 64'd1);

    // Counter wrap
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.frame_cnt;
    @(posedge clk);
    #1;
    check("frame_cnt_preload", 64'(frame_cnt), 64'hFFFF);
    capture(pat_a(), 1'b0);
    wait_drain();
    check("frame_cnt_wrap", 64'(frame_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
